// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: arbitrates two requesters onto one regfile/ALU pair,
// running each command as read, execute, writeback, respond.
package rv32ima_pkg;
  typedef logic [4:0]  reg_t;
  typedef logic [31:0] word_t;
  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU
  } aluop_t;
endpackage

module alu_op_sequencer
  import rv32ima_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  reg_t       req_rs1 [0:1],
  input  reg_t       req_rs2 [0:1],
  input  reg_t       req_rd  [0:1],
  input  aluop_t     req_op  [0:1],
  input  logic [1:0] req_wb,
  output logic [1:0] rsp_valid,
  input  logic [1:0] rsp_ready,
  output word_t      rsp_data,
  output reg_t       rf_rsel1,
  output reg_t       rf_rsel2,
  output reg_t       rf_wsel,
  output logic       rf_wen,
  output word_t      rf_wdat,
  input  word_t      rf_rdat1,
  input  word_t      rf_rdat2,
  output word_t      alu_in1,
  output word_t      alu_in2,
  output aluop_t     alu_op,
  input  word_t      alu_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB,
    S_RESP
  } state_t;

  state_t     state;
  logic       last_grant;
  logic       gnt;
  logic       take;

  reg_t       rd_q;
  aluop_t     op_q;
  logic       wb_q;
  logic       own_q;
  word_t      res_q;

  reg_t       rsel1_q;
  reg_t       rsel2_q;
  word_t      opa_q;
  word_t      opb_q;
  aluop_t     aop_q;
  reg_t       wsel_q;
  word_t      wdat_q;
  logic       wen_q;
  logic [1:0] rspv_q;
  word_t      rspd_q;

  // Tie goes to whoever did not win last time.
  always_comb begin
    gnt = 1'b0;
    unique case (1'b1)
      (req_valid == 2'b11): gnt = ~last_grant;
      (req_valid == 2'b10): gnt = 1'b1;
      default:              gnt = 1'b0;
    endcase
  end

  assign take = (state == S_IDLE) && (req_valid != 2'b00);

  always_comb begin
    req_ready = 2'b00;
    if (take && !rst) begin
      req_ready = gnt ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      rd_q       <= '0;
      op_q       <= ALU_ADD;
      wb_q       <= 1'b0;
      own_q      <= 1'b0;
      res_q      <= '0;
      rsel1_q    <= '0;
      rsel2_q    <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      aop_q      <= ALU_ADD;
      wsel_q     <= '0;
      wdat_q     <= '0;
      wen_q      <= 1'b0;
      rspv_q     <= 2'b00;
      rspd_q     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (take) begin
            rd_q       <= req_rd[gnt];
            op_q       <= req_op[gnt];
            wb_q       <= req_wb[gnt];
            own_q      <= gnt;
            last_grant <= gnt;
            rsel1_q    <= req_rs1[gnt];
            rsel2_q    <= req_rs2[gnt];
            state      <= S_READ;
          end
        end
        S_READ: begin
          opa_q   <= rf_rdat1;
          opb_q   <= rf_rdat2;
          aop_q   <= op_q;
          rsel1_q <= '0;
          rsel2_q <= '0;
          state   <= S_EXEC;
        end
        S_EXEC: begin
          res_q  <= alu_out;
          opa_q  <= '0;
          opb_q  <= '0;
          aop_q  <= ALU_ADD;
          wsel_q <= rd_q;
          wdat_q <= alu_out;
          wen_q  <= wb_q && (rd_q != '0);
          state  <= S_WB;
        end
        S_WB: begin
          wsel_q <= '0;
          wdat_q <= '0;
          wen_q  <= 1'b0;
          rspv_q <= own_q ? 2'b10 : 2'b01;
          rspd_q <= res_q;
          state  <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready[own_q]) begin
            rspv_q <= 2'b00;
            rspd_q <= '0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Reset must silence the visible strobes in the same cycle it is raised.
  assign rf_wen    = wen_q & ~rst;
  assign rsp_valid = rspv_q & {2{~rst}};
  assign rsp_data  = rst ? '0 : rspd_q;

  assign rf_rsel1 = rsel1_q;
  assign rf_rsel2 = rsel2_q;
  assign rf_wsel  = wsel_q;
  assign rf_wdat  = wdat_q;
  assign alu_in1  = opa_q;
  assign alu_in2  = opb_q;
  assign alu_op   = aop_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: random and directed stimulus with a queue-based
// scoreboard fed by a register-file reference model.
module tb_alu_op_sequencer;
  import rv32ima_pkg::*;

  typedef struct packed {
    reg_t   rs1;
    reg_t   rs2;
    reg_t   rd;
    aluop_t op;
    logic   wb;
  } cmd_t;

  typedef struct packed {
    reg_t  rd;
    word_t d;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] req_ready;
  reg_t       req_rs1 [0:1];
  reg_t       req_rs2 [0:1];
  reg_t       req_rd  [0:1];
  aluop_t     req_op  [0:1];
  logic [1:0] req_wb = 2'b00;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready = 2'b11;
  word_t      rsp_data;
  reg_t       rf_rsel1, rf_rsel2, rf_wsel;
  logic       rf_wen;
  word_t      rf_wdat, rf_rdat1, rf_rdat2;
  word_t      alu_in1, alu_in2, alu_out;
  aluop_t     alu_op;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_rd(req_rd), .req_op(req_op), .req_wb(req_wb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .rf_rsel1(rf_rsel1), .rf_rsel2(rf_rsel2),
    .rf_wsel(rf_wsel), .rf_wen(rf_wen), .rf_wdat(rf_wdat),
    .rf_rdat1(rf_rdat1), .rf_rdat2(rf_rdat2),
    .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_op(alu_op), .alu_out(alu_out)
  );

  function automatic word_t alu_f(aluop_t op, word_t a, word_t b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLL:  return a << b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return word_t'($signed(a) >>> b[4:0]);
      ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'b0, a < b};
      default:  return '0;
    endcase
  endfunction

  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endfunction

  // Environment: register file and ALU the sequencer drives.
  word_t init_rf [32];
  word_t env_rf  [32];
  logic  env_loaded = 1'b0;

  always @(posedge clk) begin
    if (!env_loaded) begin
      env_rf     <= init_rf;
      env_loaded <= 1'b1;
    end else if (rf_wen && rf_wsel != 5'd0) begin
      env_rf[rf_wsel] <= rf_wdat;
    end
  end

  assign rf_rdat1 = (rf_rsel1 == 5'd0) ? 32'd0 : env_rf[rf_rsel1];
  assign rf_rdat2 = (rf_rsel2 == 5'd0) ? 32'd0 : env_rf[rf_rsel2];
  assign alu_out  = alu_f(alu_op, alu_in1, alu_in2);

  logic       rsp_mode = 1'b0;
  logic [1:0] rsp_set  = 2'b11;

  always @(posedge clk) begin
    #1;
    rsp_ready = rsp_mode ? 2'($urandom) : rsp_set;
  end

  // Reference model and scoreboard state, owned by the monitor.
  word_t      ref_rf  [32];
  word_t      snap_rf [32];
  logic       loaded  = 1'b0;
  logic       pending = 1'b0;
  logic       wr_done = 1'b1;
  int         last_w  = 1;
  word_t      rq0 [$];
  word_t      rq1 [$];
  wr_t        wq  [$];
  int         glog [$];
  int         wen_cnt = 0;
  int         rsp_seen [2] = '{0, 0};
  word_t      last_rsp [2];
  logic [1:0] stall = 2'b00;
  word_t      held [2];
  word_t      ma, mb, mr, me;
  wr_t        mw;
  int         msz;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rf_wen", 32'(rf_wen), 0);
      chk("rst_rsp_data", rsp_data, 0);
      if (!loaded) begin
        ref_rf = init_rf;
        loaded = 1'b1;
      end
      if (pending && !wr_done) ref_rf = snap_rf;
      rq0.delete();
      rq1.delete();
      wq.delete();
      pending = 1'b0;
      wr_done = 1'b1;
      last_w  = 1;
      stall   = 2'b00;
    end else begin
      if (req_ready != 2'b00)
        chk("ready_onehot", 32'($onehot(req_ready)), 1);
      if (rsp_valid != 2'b00)
        chk("rsp_onehot", 32'($onehot(rsp_valid)), 1);
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          if (req_valid == 2'b11) chk("rr_tie", i, 1 - last_w);
          last_w = i;
          glog.push_back(i);
          ma = ref_rf[req_rs1[i]];
          mb = ref_rf[req_rs2[i]];
          mr = alu_f(req_op[i], ma, mb);
          snap_rf = ref_rf;
          pending = 1'b1;
          wr_done = 1'b1;
          if (req_wb[i] && req_rd[i] != 5'd0) begin
            ref_rf[req_rd[i]] = mr;
            wq.push_back('{req_rd[i], mr});
            wr_done = 1'b0;
          end
          if (i == 0) rq0.push_back(mr);
          else        rq1.push_back(mr);
        end
      end
      if (rf_wen) begin
        wen_cnt++;
        chk("wr_expected", 32'(wq.size() > 0), 1);
        if (wq.size() > 0) begin
          mw = wq.pop_front();
          chk("wr_sel", 32'(rf_wsel), 32'(mw.rd));
          chk("wr_data", rf_wdat, mw.d);
          wr_done = 1'b1;
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (stall[i]) begin
          chk("rsp_hold_valid", 32'(rsp_valid[i]), 1);
          chk("rsp_hold_data", rsp_data, held[i]);
        end
        stall[i] = 1'b0;
        if (rsp_valid[i]) begin
          if (rsp_ready[i]) begin
            msz = (i == 0) ? rq0.size() : rq1.size();
            chk("rsp_expected", 32'(msz > 0), 1);
            if (msz > 0) begin
              if (i == 0) me = rq0.pop_front();
              else        me = rq1.pop_front();
              chk("rsp_data", rsp_data, me);
            end
            last_rsp[i] = rsp_data;
            rsp_seen[i]++;
            pending = 1'b0;
          end else begin
            stall[i] = 1'b1;
            held[i]  = rsp_data;
          end
        end
      end
    end
  end

  function automatic cmd_t mk(int rs1, int rs2, int rd,
                              aluop_t op, logic wb);
    cmd_t c;
    c.rs1 = reg_t'(rs1);
    c.rs2 = reg_t'(rs2);
    c.rd  = reg_t'(rd);
    c.op  = op;
    c.wb  = wb;
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    return mk($urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 31),
              aluop_t'(4'($urandom_range(0, 9))),
              1'($urandom_range(0, 1)));
  endfunction

  task automatic drive(int i, cmd_t c);
    req_rs1[i]   = c.rs1;
    req_rs2[i]   = c.rs2;
    req_rd[i]    = c.rd;
    req_op[i]    = c.op;
    req_wb[i]    = c.wb;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_hs(int i);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[i] && n < 200);
    chk("hs_timeout", 32'(req_ready[i]), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send(int i, cmd_t c);
    drive(i, c);
    wait_hs(i);
    req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((rq0.size() + rq1.size() + wq.size()) != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", rq0.size() + rq1.size() + wq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic stream(int n0, int n1, bit gappy);
    int rem [2];
    int n = 0;
    logic [1:0] hs;
    rem[0] = n0;
    rem[1] = n1;
    for (int i = 0; i < 2; i++)
      if (rem[i] > 0) drive(i, rand_cmd());
    while ((rem[0] > 0 || rem[1] > 0) && n < 5000) begin
      @(negedge clk);
      n++;
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (hs[i]) begin
          rem[i]--;
          req_valid[i] = 1'b0;
        end
        if (!req_valid[i] && rem[i] > 0 &&
            (!gappy || $urandom_range(0, 3) == 0))
          drive(i, rand_cmd());
      end
    end
    chk("stream_done", rem[0] + rem[1], 0);
    req_valid = 2'b00;
  endtask

  task automatic abort_test(int depth, int rd);
    int wc;
    int s0;
    send(0, mk(1, 2, rd, ALU_ADD, 1'b1));
    repeat (depth) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(negedge clk);
    do_reset(1);
    wc = wen_cnt;
    s0 = rsp_seen[0];
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_rsp", 32'(rsp_valid), 0);
    end
    @(posedge clk);
    #1;
    drive(0, mk(2, 2, 9, ALU_ADD, 1'b1));
    drive(1, mk(1, 1, 10, ALU_ADD, 1'b1));
    @(negedge clk);
    chk("abort_tie_ready", 32'(req_ready), 32'(2'b01));
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    wait_hs(1);
    req_valid[1] = 1'b0;
    drain();
    chk("abort_rsp_count", rsp_seen[0] - s0, 1);
    chk("abort_rsp_data", last_rsp[0], 14);
    chk("abort_wen_count", wen_cnt - wc, 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int wc;
    int s0;
    int g0;
    int n;
    cmd_t c;
    for (int r = 0; r < 32; r++) init_rf[r] = (r == 0) ? 32'd0 : $urandom;
    init_rf[1] = 32'd5;
    init_rf[2] = 32'd7;
    for (int i = 0; i < 2; i++) begin
      req_rs1[i] = '0;
      req_rs2[i] = '0;
      req_rd[i]  = '0;
      req_op[i]  = ALU_ADD;
    end
    do_reset(3);

    c = mk(1, 2, 3, ALU_ADD, 1'b1);
    drive(0, c);
    @(negedge clk);
    chk("single_ready", 32'(req_ready), 32'(2'b01));
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("single_wen_read", 32'(rf_wen), 0);
    @(negedge clk);
    chk("single_wen_exec", 32'(rf_wen), 0);
    @(negedge clk);
    chk("single_wen", 32'(rf_wen), 1);
    chk("single_wsel", 32'(rf_wsel), 3);
    chk("single_wdat", rf_wdat, 12);
    @(negedge clk);
    chk("single_rsp_valid", 32'(rsp_valid), 32'(2'b01));
    chk("single_rsp_data", rsp_data, 12);
    @(posedge clk);
    #1;
    drain();

    wc = wen_cnt;
    s0 = rsp_seen[0];
    send(0, mk(2, 1, 0, ALU_SUB, 1'b1));
    drain();
    chk("x0_rsp", last_rsp[0], 2);
    send(0, mk(2, 1, 4, ALU_SUB, 1'b0));
    drain();
    chk("nowb_rsp", last_rsp[0], 2);
    chk("x0_rsp_count", rsp_seen[0] - s0, 2);
    chk("x0_no_wen", wen_cnt - wc, 0);

    drive(0, mk(1, 2, 3, ALU_ADD, 1'b1));
    wait_hs(0);
    drive(0, mk(3, 3, 4, ALU_ADD, 1'b1));
    wait_hs(0);
    req_valid[0] = 1'b0;
    drain();
    chk("chain", last_rsp[0], 24);

    rsp_set = 2'b10;
    send(0, mk(1, 2, 5, ALU_OR, 1'b1));
    drive(1, mk(5, 1, 6, ALU_ADD, 1'b1));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid[0] && n < 20);
    chk("bp_reach_resp", 32'(rsp_valid[0]), 1);
    for (int k = 0; k < 10; k++) begin
      if (k != 0) @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'(2'b01));
      chk("bp_rsp_data", rsp_data, 7);
      chk("bp_other_ready", 32'(req_ready), 0);
    end
    rsp_set = 2'b11;
    @(negedge clk);
    chk("bp_hs_cycle_ready", 32'(req_ready), 0);
    @(negedge clk);
    chk("bp_next_ready", 32'(req_ready), 32'(2'b10));
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    drain();
    chk("bp_second_rsp", last_rsp[1], 12);

    do_reset(2);
    g0 = glog.size();
    stream(4, 4, 1'b0);
    drain();
    chk("rr_count", glog.size() - g0, 8);
    for (int k = 0; k < 8 && g0 + k < glog.size(); k++)
      chk("rr_order", glog[g0 + k], k % 2);

    abort_test(1, 8);
    abort_test(2, 11);

    rsp_mode = 1'b1;
    stream(25, 25, 1'b1);
    rsp_mode = 1'b0;
    rsp_set  = 2'b11;
    drain();

    for (int r = 1; r < 32; r++)
      chk("rf_final", env_rf[r], ref_rf[r]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
